// File: rtl/shared_data_mem.sv
// shared_data_mem: register-based data memory shared by NUM_PORTS cores plus a host port.
//   - Core ports: per-port read strobe (1-cycle latency, data held until the next read on that
//     port), per-port write strobe committing at the end of the cycle it is presented.
//   - Reads are read-before-write: a read sees the contents before this cycle's writes commit.
//   - Same-address core writes in one cycle collide; the winner is the first colliding port
//     scanning round-robin from rr_ptr. Collision cycles bump a saturating counter and record
//     the lowest collided address.
//   - Host port: write strobe (dropped if any core writes the same address that cycle) and a
//     read of host_addr every cycle.
//   - Out-of-range addresses (>= DEPTH) read as 0, ignore writes and never collide.
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   mem_read_en/mem_write_en    per-port strobes, bit p = port p
//   mem_addr/mem_write_data     per-port packed address / write data, port p in slice p
//   mem_read_data               per-port packed registered read data
//   host_we/host_addr/host_wdata host write strobe, address, write data
//   host_rdata                  registered host read data
//   conflict_count              saturating count of collision cycles
//   last_conflict_addr          address of the most recent collision
module shared_data_mem #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            mem_read_en,
    input  logic [NUM_PORTS-1:0]            mem_write_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_write_data,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] mem_read_data,
    input  logic                            host_we,
    input  logic [ADDR_WIDTH-1:0]           host_addr,
    input  logic [DATA_WIDTH-1:0]           host_wdata,
    output logic [DATA_WIDTH-1:0]           host_rdata,
    output logic [7:0]                      conflict_count,
    output logic [ADDR_WIDTH-1:0]           last_conflict_addr
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_WIDTH-1:0] r_mem       [DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_d     [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data   [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] w_addr      [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wdata     [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_wr_valid;
    logic [NUM_PORTS-1:0]  w_commit;
    logic [NUM_PORTS-1:0]  w_coll;
    logic                  w_any_coll;
    logic [ADDR_WIDTH-1:0] w_coll_addr;
    logic                  w_host_commit;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_rr_next;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic [7:0]            r_conflict_count;
    logic [ADDR_WIDTH-1:0] r_last_conflict_addr;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Position of port p in the round-robin scan starting at ptr (0 = highest priority).
    function automatic int unsigned rank(input int unsigned p, input logic [PTR_W-1:0] ptr);
        return (p + NUM_PORTS - 32'(ptr)) % NUM_PORTS;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a == ADDR_WIDTH'(i)) v = r_mem[i];
        end
        return v;
    endfunction

    always_comb begin
        w_wr_valid = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_addr[p]     = mem_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata[p]    = mem_write_data[p*DATA_WIDTH +: DATA_WIDTH];
            w_wr_valid[p] = mem_write_en[p] && in_range(w_addr[p]);
        end
    end

    // A port loses when another valid writer to the same address sits earlier in the scan.
    always_comb begin
        w_commit    = w_wr_valid;
        w_coll      = '0;
        w_any_coll  = 1'b0;
        w_coll_addr = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                if (q != p && w_wr_valid[p] && w_wr_valid[q] && w_addr[p] == w_addr[q]) begin
                    w_coll[p] = 1'b1;
                    if (rank(q, r_rr_ptr) < rank(p, r_rr_ptr)) w_commit[p] = 1'b0;
                end
            end
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_coll[p] && (!w_any_coll || w_addr[p] < w_coll_addr)) begin
                w_any_coll  = 1'b1;
                w_coll_addr = w_addr[p];
            end
        end
    end

    always_comb begin
        w_host_commit = host_we && in_range(host_addr);
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_wr_valid[p] && w_addr[p] == host_addr) w_host_commit = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem[i];
            if (w_host_commit && host_addr == ADDR_WIDTH'(i)) w_mem_d[i] = host_wdata;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (w_commit[p] && w_addr[p] == ADDR_WIDTH'(i)) w_mem_d[i] = w_wdata[p];
            end
        end
    end

    assign w_rr_next = PTR_W'((32'(r_rr_ptr) + 1) % NUM_PORTS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) r_rd_data[p] <= '0;
            r_host_rdata         <= '0;
            r_conflict_count     <= '0;
            r_last_conflict_addr <= '0;
            r_rr_ptr             <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_d[i];
            // Reads use r_mem (pre-write contents), giving read-before-write.
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (mem_read_en[p]) r_rd_data[p] <= rd_word(w_addr[p]);
            end
            r_host_rdata <= rd_word(host_addr);
            if (w_any_coll) begin
                r_rr_ptr             <= w_rr_next;
                r_last_conflict_addr <= w_coll_addr;
                if (r_conflict_count != 8'hFF) r_conflict_count <= r_conflict_count + 8'd1;
            end
        end
    end

    always_comb begin
        mem_read_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            mem_read_data[p*DATA_WIDTH +: DATA_WIDTH] = r_rd_data[p];
        end
    end

    assign host_rdata         = r_host_rdata;
    assign conflict_count     = r_conflict_count;
    assign last_conflict_addr = r_last_conflict_addr;

endmodule

// File: tb/tb_shared_data_mem.sv
module tb_shared_data_mem;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_read_en;
    logic [1:0]  mem_write_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic [7:0]  conflict_count;
    logic [3:0]  last_conflict_addr;

    int n_checks = 0;
    int n_fail   = 0;

    shared_data_mem dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_en       (mem_read_en),
        .mem_write_en      (mem_write_en),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .host_we           (host_we),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .host_rdata        (host_rdata),
        .conflict_count    (conflict_count),
        .last_conflict_addr(last_conflict_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_en    = 2'b00;
        mem_write_en   = 2'b00;
        host_we        = 1'b0;
    endtask

    // Host read of address a: returns contents present at the sampling edge.
    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        idle_inputs();
        host_addr = a;
        step();
        d = host_rdata;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        idle_inputs();
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        step();
        host_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (mem_read_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_read_data: got %h expected %h", mem_read_data, 16'h0);
        end
        n_checks++;
        if (host_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_host_rdata: got %h expected %h", host_rdata, 8'h0);
        end
        n_checks++;
        if (conflict_count !== 8'd0 || last_conflict_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_conflict: got count=%0d addr=%0d expected 0/0",
                     conflict_count, last_conflict_addr);
        end
    endtask

    task automatic test_read_hold();
        host_write(4'd0, 8'd3);
        host_write(4'd1, 8'd5);
        host_write(4'd2, 8'd7);
        host_write(4'd3, 8'd11);
        mem_read_en = 2'b01;
        mem_addr    = {4'd0, 4'd1};
        step();
        n_checks++;
        if (mem_read_data[7:0] !== 8'd5) begin
            n_fail++; $display("FAIL read_latency: got %0d expected %0d", mem_read_data[7:0], 5);
        end
        mem_read_en = 2'b00;
        mem_addr    = {4'd0, 4'd3};
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (mem_read_data[7:0] !== 8'd5) begin
                n_fail++;
                $display("FAIL read_hold[%0d]: got %0d expected %0d", i, mem_read_data[7:0], 5);
            end
        end
    endtask

    task automatic test_parallel_write();
        logic [7:0] d;
        mem_write_en   = 2'b11;
        mem_addr       = {4'd9, 4'd8};
        mem_write_data = {8'h12, 8'h08};
        step();
        idle_inputs();
        peek(4'd8, d);
        n_checks++;
        if (d !== 8'h08) begin
            n_fail++; $display("FAIL parallel_wr_p0: got %h expected %h", d, 8'h08);
        end
        peek(4'd9, d);
        n_checks++;
        if (d !== 8'h12) begin
            n_fail++; $display("FAIL parallel_wr_p1: got %h expected %h", d, 8'h12);
        end
        n_checks++;
        if (conflict_count !== 8'd0) begin
            n_fail++; $display("FAIL parallel_no_conflict: got %0d expected 0", conflict_count);
        end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        mem_write_en   = 2'b11;
        mem_addr       = {4'd8, 4'd8};
        mem_write_data = {8'h22, 8'h11};
        step();
        n_checks++;
        if (conflict_count !== 8'd1 || last_conflict_addr !== 4'd8) begin
            n_fail++;
            $display("FAIL coll1_stats: got count=%0d addr=%0d expected 1/8",
                     conflict_count, last_conflict_addr);
        end
        peek(4'd8, d);
        n_checks++;
        if (d !== 8'h11) begin
            n_fail++; $display("FAIL coll1_winner: got %h expected %h", d, 8'h11);
        end
        // Pointer has advanced to port 1.
        mem_write_en   = 2'b11;
        mem_addr       = {4'd8, 4'd8};
        mem_write_data = {8'h44, 8'h33};
        step();
        n_checks++;
        if (conflict_count !== 8'd2) begin
            n_fail++; $display("FAIL coll2_count: got %0d expected 2", conflict_count);
        end
        peek(4'd8, d);
        n_checks++;
        if (d !== 8'h44) begin
            n_fail++; $display("FAIL coll2_winner: got %h expected %h", d, 8'h44);
        end
    endtask

    task automatic test_read_before_write();
        host_write(4'd4, 8'd7);
        mem_write_en   = 2'b01;
        mem_read_en    = 2'b10;
        mem_addr       = {4'd4, 4'd4};
        mem_write_data = {8'h00, 8'hAA};
        step();
        n_checks++;
        if (mem_read_data[15:8] !== 8'd7) begin
            n_fail++; $display("FAIL rbw_old: got %h expected %h", mem_read_data[15:8], 8'd7);
        end
        mem_write_en = 2'b00;
        step();
        n_checks++;
        if (mem_read_data[15:8] !== 8'hAA) begin
            n_fail++; $display("FAIL rbw_new: got %h expected %h", mem_read_data[15:8], 8'hAA);
        end
        n_checks++;
        if (mem_read_data[7:0] !== 8'd5) begin
            n_fail++; $display("FAIL rbw_p0_held: got %h expected %h", mem_read_data[7:0], 8'd5);
        end
        mem_read_en = 2'b00;
    endtask

    task automatic test_host_loses();
        logic [7:0] d;
        host_we        = 1'b1;
        host_addr      = 4'd2;
        host_wdata     = 8'h55;
        mem_write_en   = 2'b01;
        mem_addr       = {4'd0, 4'd2};
        mem_write_data = {8'h00, 8'h66};
        step();
        idle_inputs();
        peek(4'd2, d);
        n_checks++;
        if (d !== 8'h66) begin
            n_fail++; $display("FAIL host_loses: got %h expected %h", d, 8'h66);
        end
        n_checks++;
        if (conflict_count !== 8'd2) begin
            n_fail++; $display("FAIL host_no_conflict: got %0d expected 2", conflict_count);
        end
    endtask

    task automatic test_reset_discard();
        logic [7:0] d;
        reset          = 1'b1;
        mem_write_en   = 2'b01;
        mem_addr       = {4'd0, 4'd5};
        mem_write_data = {8'h00, 8'h99};
        step();
        reset = 1'b0;
        idle_inputs();
        n_checks++;
        if (mem_read_data !== 16'h0000 || host_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL rst2_read_data: got %h/%h expected 0000/00", mem_read_data, host_rdata);
        end
        n_checks++;
        if (conflict_count !== 8'd0 || last_conflict_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL rst2_conflict: got count=%0d addr=%0d expected 0/0",
                     conflict_count, last_conflict_addr);
        end
        peek(4'd5, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL rst2_discard: got %h expected %h", d, 8'h00);
        end
        peek(4'd1, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL rst2_array_clear: got %h expected %h", d, 8'h00);
        end
    endtask

    // After reset the pointer is back at port 0; then drive the counter into saturation.
    task automatic test_saturation();
        logic [7:0] d;
        mem_write_en   = 2'b11;
        mem_addr       = {4'd7, 4'd7};
        mem_write_data = {8'h02, 8'h01};
        step();
        idle_inputs();
        peek(4'd7, d);
        n_checks++;
        if (d !== 8'h01) begin
            n_fail++; $display("FAIL rr_after_reset: got %h expected %h", d, 8'h01);
        end
        n_checks++;
        if (last_conflict_addr !== 4'd7) begin
            n_fail++; $display("FAIL last_addr_7: got %0d expected 7", last_conflict_addr);
        end
        mem_write_en = 2'b11;
        mem_addr     = {4'd3, 4'd3};
        for (int i = 0; i < 260; i++) step();
        idle_inputs();
        n_checks++;
        if (conflict_count !== 8'd255 || last_conflict_addr !== 4'd3) begin
            n_fail++;
            $display("FAIL saturate: got count=%0d addr=%0d expected 255/3",
                     conflict_count, last_conflict_addr);
        end
    endtask

    initial begin
        reset          = 1'b1;
        mem_read_en    = 2'b00;
        mem_write_en   = 2'b00;
        mem_addr       = 8'h00;
        mem_write_data = 16'h0000;
        host_we        = 1'b0;
        host_addr      = 4'd0;
        host_wdata     = 8'h00;
        test_reset();
        test_read_hold();
        test_parallel_write();
        test_collision();
        test_read_before_write();
        test_host_loses();
        test_reset_discard();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
